seq_shift_unit: RTL and testbench

Iterative 32-bit shift unit for KGP_RISC, complementing the single-cycle combinational logical shifter. Performs one bit position per clock with a start/busy/done handshake. Adds arithmetic right shift, which the logical path cannot produce, and optional rotate. Sits beside the ALU for multi-cycle `sra`/`srav`-class instructions and area-reduced builds.

---
 rtl/kgp_shift_pkg.sv | 27 ++
 rtl/shift_step.sv | 38 +++
 rtl/seq_shift_unit.sv | 111 +++++++++++
 tb/tb_seq_shift_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kgp_shift_pkg.sv
// ---------------------------------------------------------------------------
// kgp_shift_pkg
// Shared definitions for the KGP_RISC shift datapath: datapath and count
// widths, shift operation encodings, and the sequential shifter state enum.
// Also imported by the instruction decoder and the ALU.
// ---------------------------------------------------------------------------
package kgp_shift_pkg;

  localparam int WIDTH = 32;              // datapath width, fixed for KGP_RISC
  localparam int CNT_W = $clog2(WIDTH);   // shift-count width (5)

  // Shift operation encodings as carried on the 2-bit op field.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  // Sequential shifter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage : kgp_shift_pkg

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-bit shift step used by seq_shift_unit.
//
// Build option: SEQ_SHIFT_ROTATE_EN
//   defined     -> SH_ROR rotates right by one bit
//   not defined -> SH_ROR decodes as a logical right shift (no rotate path)
//
// Ports:
//   i_res  in  WIDTH  current partial result
//   i_op   in  2      shift operation (sh_op_e)
//   o_res  out WIDTH  partial result after one bit step
// ---------------------------------------------------------------------------
module shift_step
  import kgp_shift_pkg::*;
(
  input  logic [WIDTH-1:0] i_res,
  input  sh_op_e           i_op,
  output logic [WIDTH-1:0] o_res
);

  always_comb begin
    // NOTE: the default assignment first means every path drives o_res, so no latch is inferred.
    o_res = {1'b0, i_res[WIDTH-1:1]};
    case (i_op)
      SH_SLL: o_res = {i_res[WIDTH-2:0], 1'b0};
      SH_SRL: o_res = {1'b0, i_res[WIDTH-1:1]};
      SH_SRA: o_res = {i_res[WIDTH-1], i_res[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      SH_ROR: o_res = {i_res[0], i_res[WIDTH-1:1]};
`else
      SH_ROR: o_res = {1'b0, i_res[WIDTH-1:1]};
`endif
      default: o_res = {1'b0, i_res[WIDTH-1:1]};
    endcase
  end

endmodule : shift_step

// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
// Iterative 32-bit shifter for KGP_RISC: one bit position per clock, with a
// start/busy/done handshake. Supports sll, srl, sra and (optionally) ror.
//
// Build option: SEQ_SHIFT_ROTATE_EN (enables rotate right for op = 2'b11;
// otherwise op = 2'b11 behaves as srl). Passed through to shift_step.
//
// Ports:
//   clk    in  1      system clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, sampled only when not busy
//   A      in  WIDTH  operand, captured on accepted start
//   shamt  in  WIDTH  shift amount, only low CNT_W bits used
//   op     in  2      00 sll, 01 srl, 10 sra, 11 ror
//   res    out WIDTH  result, valid with done, held until next accepted start
//   busy   out 1      high while shifting
//   done   out 1      one-cycle pulse when res becomes valid
// ---------------------------------------------------------------------------
module seq_shift_unit
  import kgp_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] shamt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  state_e             r_state;
  sh_op_e             r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_step;
  logic [CNT_W-1:0]   w_n;
  logic               w_unused;

  assign w_n      = shamt[CNT_W-1:0];
  // Upper shift-amount bits are architecturally ignored.
  assign w_unused = ^shamt[WIDTH-1:CNT_W];

  shift_step u_step (
    .i_res (r_res),
    .i_op  (r_op),
    .o_res (w_step)
  );

  // Single FSM block; busy/done are registered alongside the state so they
  // are glitch-free and never high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= SH_SLL;
      r_cnt   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_res <= A;
            r_op  <= sh_op_e'(op);
            r_cnt <= w_n;
            if (w_n != '0) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end else begin
              // Zero shift: result is the operand, signal done next cycle.
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        SHIFT: begin
          // start is deliberately ignored here; no request queuing.
          r_res <= w_step;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign res  = r_res;
  assign busy = r_busy;
  assign done = r_done;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_unit
// Scoreboard bench for seq_shift_unit. The driver decides from its own model
// whether a start is accepted and pushes the expected result and timing; an
// independent monitor on the falling edge checks busy/done every cycle and
// the result when done is due.
// Honors SEQ_SHIFT_ROTATE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_seq_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] shamt;
  logic [1:0]  op;
  logic [31:0] res;
  logic        busy;
  logic        done;

  seq_shift_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .shamt (shamt),
    .op    (op),
    .res   (res),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp_res;
    int          acc;   // cycle in which the DUT is first in its post-accept state
    int          n;     // effective shift amount
  } txn_t;

  txn_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          last_free = 0;      // first cycle in which a new start is accepted
  logic [31:0] last_exp = '0;      // value res must hold while idle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural reference: whole shift in one arithmetic expression.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n, input logic [1:0] o);
    case (o)
      2'b00: return a << n;
      2'b01: return a >> n;
      2'b10: return $unsigned($signed(a) >>> n);
`ifdef SEQ_SHIFT_ROTATE_EN
      default: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
`else
      default: return a >> n;
`endif
    endcase
  endfunction

  // Monitor: decoupled from the driver, reads only the scoreboard queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_res", res, 32'd0);
    end else if (sb_q.size() == 0) begin
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_done", {31'b0, done}, 32'd0);
      check("idle_res_hold", res, last_exp);
    end else begin
      txn_t t;
      logic exp_busy;
      logic exp_done;
      t        = sb_q[0];
      exp_busy = (cyc >= t.acc) && (cyc < t.acc + t.n);
      exp_done = (cyc == t.acc + t.n);
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        check("result", res, t.exp_res);
        last_exp = t.exp_res;
        void'(sb_q.pop_front());
      end
    end
  end

  // Driver helpers: all input changes happen 2 time units after the falling edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Present one request for a single cycle; record it if the DUT will accept it.
  task automatic issue(input logic [31:0] a, input logic [31:0] sh, input logic [1:0] o,
                       input logic [31:0] exp);
    txn_t t;
    a_in  = a;
    shamt = sh;
    op    = o;
    start = 1'b1;
    if (cyc >= last_free) begin
      t.exp_res = exp;
      t.acc     = cyc + 1;
      t.n       = int'(sh[4:0]);
      sb_q.push_back(t);
      last_free = t.acc + t.n;
    end
    tick();
    start = 1'b0;
    a_in  = $urandom();
    op    = 2'($urandom());
  endtask

  task automatic issue_rand(input logic [31:0] a, input logic [31:0] sh, input logic [1:0] o);
    issue(a, sh, o, ref_shift(a, int'(sh[4:0]), o));
  endtask

  task automatic drain();
    int budget = 100;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    sb_q.delete();
    last_exp = '0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    last_free = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    shamt = '0;
    op    = '0;
    repeat (3) tick();
    do_reset(2);
    tick();

    // Directed cases with hand-derived results.
    issue(32'hCCC9CCC9, 32'd5, 2'b00, 32'h99399920);
    drain();
    issue(32'h80000000, 32'd4, 2'b10, 32'hF8000000);
    drain();
    issue(32'h80000000, 32'd4, 2'b01, 32'h08000000);
    drain();
    issue(32'hF27339C9, 32'h00000020, 2'b01, 32'hF27339C9);
    drain();
`ifdef SEQ_SHIFT_ROTATE_EN
    issue(32'h00000001, 32'd1, 2'b11, 32'h80000000);
`else
    issue(32'h00000001, 32'd1, 2'b11, 32'h00000000);
`endif
    drain();
    issue(32'hFFFFFFFF, 32'd31, 2'b10, 32'hFFFFFFFF);
    drain();

    // Start during SHIFT is ignored; start in the DONE cycle is taken at once.
    issue(32'hFFFFFFFF, 32'd8, 2'b00, 32'hFFFFFF00);
    tick();
    issue(32'h12345678, 32'd3, 2'b01, 32'h0);          // model marks as not accepted
    while (cyc < last_free) tick();
    issue(32'h80000001, 32'd1, 2'b10, 32'hC0000000);   // lands in the DONE cycle
    drain();

    // Reset two cycles into a 10-bit shift: aborts with no done.
    issue(32'hA5A5A5A5, 32'd10, 2'b01, 32'h0);
    tick();
    do_reset(2);
    tick();
    issue(32'h0000F00F, 32'd4, 2'b00, 32'h000F00F0);
    drain();

    // Randomized traffic, including starts that collide with SHIFT.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        issue_rand($urandom(), $urandom(), 2'($urandom()));
      else
        tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_shift_unit
